// File: rtl/mux_pkg.sv
// Shared constants and helpers for the 32-channel mux/demux pair.
// Channel k of a flattened bus occupies bits [k*DATA_W +: DATA_W].
package mux_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 5;
    localparam int unsigned N_CH   = 1 << SEL_W;

    function automatic logic [DATA_W-1:0] ch_slice(input logic [N_CH*DATA_W-1:0] bus,
                                                   input int unsigned k);
        return bus[k*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/demux_ch_slot.sv
// One demux channel: data holding register, valid flag cleared by ack, sticky overrun flag.
module demux_ch_slot #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OVERWRITE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             ack_i,
    input  logic             ovr_clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             valid_d_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (ack_i && valid_q) begin
            valid_d = 1'b0;
        end
        // A write in the same cycle as an ack refills the slot; the ack consumed the old word.
        if (wr_en_i) begin
            data_d  = wr_data_i;
            valid_d = 1'b1;
        end
        if (ovr_clr_i) begin
            overrun_d = 1'b0;
        end
        // Set has priority over clear.
        if ((OVERWRITE != 0) && wr_en_i && valid_q && !ack_i) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign valid_d_o = valid_d;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/demux1t32_32_reg.sv
// Registered 1-to-32 demultiplexer: select decode, ready generation and occupancy count
// around 32 channel slots.
module demux1t32_32_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH     = mux_pkg::DATA_W,
    parameter int unsigned SEL_W     = mux_pkg::SEL_W,
    parameter int unsigned OVERWRITE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic [WIDTH-1:0]              in_data,
    output logic [(2**SEL_W)*WIDTH-1:0]   out_data,
    output logic [(2**SEL_W)-1:0]         out_valid,
    input  logic [(2**SEL_W)-1:0]         out_ack,
    output logic [(2**SEL_W)-1:0]         overrun,
    output logic [SEL_W:0]                occupancy,
    input  logic                          ovr_clr
);

    localparam int unsigned N = 2**SEL_W;

    logic [N-1:0]   sel_oh;
    logic [N-1:0]   valid_d;
    logic           accept;
    logic [SEL_W:0] occupancy_q, occupancy_d;

    always_comb begin
        sel_oh = '0;
        for (int k = 0; k < N; k++) begin
            sel_oh[k] = (in_sel == SEL_W'(k));
        end
    end

    if (OVERWRITE != 0) begin : g_ready_ovw
        assign in_ready = 1'b1;
    end else begin : g_ready_bp
        assign in_ready = ~out_valid[in_sel] | out_ack[in_sel];
    end

    // in_valid gates first so an X select while idle cannot reach any slot.
    assign accept = in_valid & in_ready;

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_ch_slot #(
            .WIDTH     (WIDTH),
            .OVERWRITE (OVERWRITE)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en_i   (accept & sel_oh[k]),
            .wr_data_i (in_data),
            .ack_i     (out_ack[k]),
            .ovr_clr_i (ovr_clr),
            .data_o    (out_data[k*WIDTH +: WIDTH]),
            .valid_o   (out_valid[k]),
            .valid_d_o (valid_d[k]),
            .overrun_o (overrun[k])
        );
    end

    // Count next-state valids so the registered count tracks out_valid exactly.
    always_comb begin
        occupancy_d = '0;
        for (int k = 0; k < N; k++) begin
            occupancy_d = occupancy_d + {{SEL_W{1'b0}}, valid_d[k]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign occupancy = occupancy_q;

endmodule
